// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-path constants and the {pc, instruction} bundle type.
// Reused by the cache, decode and execute stages.
`ifndef INSTRUCTION_FETCH_PKG_SV
`define INSTRUCTION_FETCH_PKG_SV

package instruction_fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] align_pc(
        input logic [ADDR_WIDTH-1:0] a
    );
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

`endif

// File: rtl/instruction_fetch_queue.sv
// Circular fetch queue; pointers wrap naturally, flush empties it.
// Storage is not reset: the head is only meaningful while not empty.
module instruction_fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop_ok;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues cache reads, queues {pc, instr}
// pairs for decode and squashes in-flight work on a redirect.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic [ADDR_WIDTH-1:0]  PC,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]  out_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;

    logic          deq;
    logic          push;
    logic          issue;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    assign PC        = fetch_pc;
    assign out_valid = !empty;
    assign deq       = out_valid && out_ready;
    assign push      = inflight && !redirect_valid;

    // Credit: entries held plus the response already on its way.
    assign occupancy = count + CW'(inflight) - CW'(deq);
    assign issue     = !redirect_valid && (occupancy < CW'(QUEUE_DEPTH));

    assign push_data.pc    = inflight_pc;
    assign push_data.instr = instruction;

    assign out_instruction = empty ? '0 : head.instr;
    assign out_pc          = empty ? '0 : head.pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_STEP;
        end else begin
            inflight <= 1'b0;
        end
    end

    instruction_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (deq),
        .flush     (redirect_valid),
        .push_data (push_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    a_no_overflow: assert property (
        @(posedge clock) disable iff (!reset_n) !(push && full)
    );

endmodule
